// File: rtl/dma_read_engine.sv
// dma_read_engine: runs one DMA read transaction at a time. It issues word
// reads to external memory with up to MAX_OUTST reads in flight. Each in-order
// response is registered and then written into the accelerator buffer. done
// pulses once when the transfer completes.
// Optional feature macro: DMA_READ_PERF_EN adds the perf_cycles counter port.
module dma_read_engine #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 16,
  parameter int MAX_OUTST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_en,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [ADDR_W-1:0] req_dst,
  output logic              req_ack,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_rd_valid,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_ready,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              buf_wr_en,
  output logic [ADDR_W-1:0] buf_wr_addr,
  output logic [DATA_W-1:0] buf_wr_data
`ifdef DMA_READ_PERF_EN
  ,
  output logic [31:0]       perf_cycles
`endif
);

  localparam int OUT_W = $clog2(MAX_OUTST + 1);
  localparam logic [OUT_W-1:0]  OUT_MAX = OUT_W'(MAX_OUTST);
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(DATA_W / 8);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  issued;
  logic [LEN_W-1:0]  received;
  logic [OUT_W-1:0]  outst;
  logic              err_q;
  logic              rsp_q_valid;
  logic [DATA_W-1:0] rsp_q_data;

  logic rd_hs;
  logic rsp_ok;
  logic stray;

  // A response is only legitimate when a read is in flight. Any other response
  // is stray: it is dropped and it flags an error.
  assign rd_hs  = mem_rd_valid & mem_rd_ready;
  assign rsp_ok = mem_rsp_valid & (outst != '0);
  assign stray  = mem_rsp_valid & (outst == '0);

  assign busy        = (state != S_IDLE);
  assign err         = err_q;
  assign mem_rd_addr = rd_addr;
  assign buf_wr_en   = rsp_q_valid;
  assign buf_wr_addr = wr_addr;
  assign buf_wr_data = rsp_q_data;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic and the handshake outputs that are decoded from state.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_next   = state;
    req_ack      = 1'b0;
    mem_rd_valid = 1'b0;
    done         = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req_en) begin
          req_ack    = 1'b1;
          state_next = (req_len == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        // The address holds under backpressure. outst can only fall while
        // valid is up, so valid stays high until the request is taken.
        mem_rd_valid = (issued < len) && (outst < OUT_MAX);
        if (issued == len) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (received == len) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Transfer bookkeeping: addresses, counters and the sticky error flag.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register in this block samples its pre-edge values.
    if (!rst_n) begin
      rd_addr  <= '0;
      wr_addr  <= '0;
      len      <= '0;
      issued   <= '0;
      received <= '0;
      outst    <= '0;
      err_q    <= 1'b0;
    end else if (req_ack) begin
      rd_addr  <= req_addr;
      wr_addr  <= req_dst;
      len      <= req_len;
      issued   <= '0;
      received <= '0;
      outst    <= '0;
      err_q    <= 1'b0;
    end else begin
      if (rd_hs) begin
        rd_addr <= rd_addr + STEP;
        issued  <= issued + LEN_W'(1);
      end
      if (rsp_ok) received <= received + LEN_W'(1);
      unique case ({rd_hs, rsp_ok})
        2'b10:   outst <= outst + OUT_W'(1);
        2'b01:   outst <= outst - OUT_W'(1);
        default: outst <= outst;
      endcase
      if (stray)       err_q   <= 1'b1;
      if (rsp_q_valid) wr_addr <= wr_addr + STEP;
    end
  end

  // Response register stage that feeds the buffer write port.
  always_ff @(posedge clk) begin
    // NOTE: the data register is reset along with its valid bit. This keeps buf_wr_data at 0 out of reset, and it is a single register, not a memory array.
    if (!rst_n) begin
      rsp_q_valid <= 1'b0;
      rsp_q_data  <= '0;
    end else begin
      rsp_q_valid <= rsp_ok;
      if (rsp_ok) rsp_q_data <= mem_rsp_data;
    end
  end

`ifdef DMA_READ_PERF_EN
  // Busy-cycle counter: cleared on accept, counts through the done cycle, saturating.
  always_ff @(posedge clk) begin
    if (!rst_n)                                  perf_cycles <= '0;
    else if (req_ack)                            perf_cycles <= '0;
    else if (busy && (perf_cycles != '1))        perf_cycles <= perf_cycles + 32'd1;
  end
`endif

endmodule
